// File: rtl/display_scan.sv
// display_scan: time-multiplexed 7-segment digit scanner.
//
// Presents one nibble of a double-buffered packed value per scan slot and
// drives one-hot digit enables. Each slot begins with a dark guard interval.
// Leading zeros are optionally suppressed. New values are taken from the
// shadow register only at frame boundaries, so a frame never mixes two values.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   value_in   packed value, nibble k = value_in[4k+3:4k], digit 0 = LSD
//   load       single-cycle strobe, captures value_in into the shadow register
//   lz_en      1 = suppress leading zeros (registered before use)
//   bcd_out    nibble of the current digit
//   dig_en     one-hot active-high digit enable
//   blank      1 = current slot dark
//   frame_done one-cycle pulse after each frame boundary
module display_scan #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned PRESCALE     = 50000,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    load,
   input  logic                    lz_en,
   output logic [3:0]              bcd_out,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    blank,
   output logic                    frame_done
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned VW = 4 * NUM_DIGITS;

   logic [VW-1:0] shadow_q, shadow_d;
   logic [VW-1:0] active_q, active_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          frame_done_q, frame_done_d;
   logic          lz_en_q;

   logic          slot_end;
   logic          frame_end;

   always_comb begin
      slot_end  = (presc_q == PW'(PRESCALE - 1));
      frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

      presc_d = slot_end ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end

      shadow_d = load ? value_in : shadow_q;
      // A load coinciding with the boundary bypasses the shadow register.
      active_d = active_q;
      if (frame_end) begin
         active_d = load ? value_in : shadow_q;
      end
      frame_done_d = frame_end;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_q     <= '0;
         active_q     <= '0;
         presc_q      <= '0;
         idx_q        <= '0;
         frame_done_q <= 1'b0;
         lz_en_q      <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         frame_done_q <= frame_done_d;
         lz_en_q      <= lz_en;
      end
   end

   // upper_zero[k]: nibbles k..NUM_DIGITS-1 of the active value are all zero.
   logic [NUM_DIGITS-1:0] upper_zero;
   logic                  sup;
   logic                  guard;

   always_comb begin
      upper_zero = '0;
      upper_zero[NUM_DIGITS-1] = (active_q[VW-1 -: 4] == 4'h0);
      for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
         upper_zero[k] = upper_zero[k+1] && (active_q[4*k +: 4] == 4'h0);
      end

      bcd_out = 4'h0;
      sup     = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            bcd_out = active_q[4*k +: 4];
            // Digit 0 is never suppressed so a zero value still shows "0".
            sup     = lz_en_q && (k != 0) && upper_zero[k];
         end
      end

      guard = (32'(presc_q) < BLANK_CYCLES);
      blank = guard || sup;

      dig_en = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         dig_en[k] = !blank && (idx_q == IW'(k));
      end
   end

   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

   localparam int unsigned N  = 4;
   localparam int unsigned PS = 4;
   localparam int unsigned BC = 1;
   localparam int unsigned FRAME = N * PS;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] value_in;
   logic        load;
   logic        lz_en;
   logic [3:0]  bcd_out;
   logic [3:0]  dig_en;
   logic        blank;
   logic        frame_done;

   display_scan #(
      .NUM_DIGITS  (N),
      .PRESCALE    (PS),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .value_in  (value_in),
      .load      (load),
      .lz_en     (lz_en),
      .bcd_out   (bcd_out),
      .dig_en    (dig_en),
      .blank     (blank),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: cycles elapsed since reset plus the two value registers.
   int          m_t;
   logic [15:0] m_shadow;
   logic [15:0] m_active;
   logic        m_lz;
   logic [15:0] m_lastval;

   logic [3:0]  e_bcd;
   logic [3:0]  e_en;
   logic        e_blank;
   logic        e_fd;

   task automatic tick(input logic rst, input logic ld, input logic [15:0] v, input logic lz);
      int p;
      int i;
      logic [15:0] upper;
      rst_n    = rst;
      load     = ld;
      value_in = v;
      lz_en    = lz;
      @(posedge clk);
      if (!rst) begin
         m_t      = 0;
         m_shadow = 16'h0;
         m_active = 16'h0;
         m_lz     = 1'b0;
      end else begin
         if (m_t % FRAME == FRAME - 1) m_active = ld ? v : m_shadow;
         if (ld) m_shadow = v;
         m_lz = lz;
         m_t++;
      end
      @(negedge clk);
      p       = m_t % PS;
      i       = (m_t / PS) % N;
      upper   = m_active >> (4 * i);
      e_bcd   = upper[3:0];
      e_blank = (p < BC) || (m_lz && i > 0 && upper == 16'h0);
      e_en    = e_blank ? 4'h0 : 4'(1 << i);
      e_fd    = (m_t > 0) && (m_t % FRAME == 0);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (dig_en !== 4'h0 || blank !== 1'b1 || bcd_out !== 4'h0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got en=%b bl=%b bcd=%h fd=%b exp en=0000 bl=1 bcd=0 fd=0",
                  dig_en, blank, bcd_out, frame_done);
      end
      for (int c = 0; c < 3; c++) begin
         tick(1'b1, 1'b0, 16'h0, 1'b0);
         checks++;
         if (dig_en !== 4'b0001 || bcd_out !== 4'h0 || blank !== 1'b0) begin
            errors++;
            $display("FAIL reset_release c=%0d got en=%b bcd=%h bl=%b exp en=0001 bcd=0 bl=0",
                     c, dig_en, bcd_out, blank);
         end
      end
   endtask

   task automatic test_load_frame();
      tick(1'b0, 1'b0, 16'h0, 1'b0);
      tick(1'b1, 1'b1, 16'h1234, 1'b0);
      for (int c = 0; c < 2 * FRAME; c++) begin
         tick(1'b1, 1'b0, 16'h0, 1'b0);
         checks++;
         if ({bcd_out, dig_en, blank, frame_done} !== {e_bcd, e_en, e_blank, e_fd}) begin
            errors++;
            $display("FAIL load_frame t=%0d got bcd=%h en=%b bl=%b fd=%b exp bcd=%h en=%b bl=%b fd=%b",
                     m_t, bcd_out, dig_en, blank, frame_done, e_bcd, e_en, e_blank, e_fd);
         end
         if (m_t == FRAME) begin
            checks++;
            if (frame_done !== 1'b1) begin
               errors++;
               $display("FAIL frame_done_16 got %b exp 1", frame_done);
            end
         end
      end
   endtask

   task automatic test_lz();
      logic [15:0] vals [3] = '{16'h0042, 16'h0000, 16'h0402};
      foreach (vals[j]) begin
         tick(1'b1, 1'b1, vals[j], 1'b1);
         for (int c = 0; c < 2 * FRAME; c++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b1);
            checks++;
            if ({bcd_out, dig_en, blank, frame_done} !== {e_bcd, e_en, e_blank, e_fd}) begin
               errors++;
               $display("FAIL lz v=%h t=%0d got bcd=%h en=%b bl=%b exp bcd=%h en=%b bl=%b",
                        vals[j], m_t, bcd_out, dig_en, blank, e_bcd, e_en, e_blank);
            end
         end
      end
   endtask

   task automatic test_no_tear();
      tick(1'b1, 1'b1, 16'h1111, 1'b0);
      while (m_t % FRAME != 0) tick(1'b1, 1'b0, 16'h0, 1'b0);
      while (m_t % FRAME != PS + 1) tick(1'b1, 1'b0, 16'h0, 1'b0);
      tick(1'b1, 1'b1, 16'h2222, 1'b0);
      for (int c = 0; c < 2 * FRAME; c++) begin
         tick(1'b1, 1'b0, 16'h0, 1'b0);
         checks++;
         if ({bcd_out, dig_en, blank, frame_done} !== {e_bcd, e_en, e_blank, e_fd}) begin
            errors++;
            $display("FAIL no_tear t=%0d got bcd=%h en=%b exp bcd=%h en=%b",
                     m_t, bcd_out, dig_en, e_bcd, e_en);
         end
      end
   endtask

   task automatic test_boundary_load();
      tick(1'b1, 1'b1, 16'h5555, 1'b0);
      while (m_t % FRAME != FRAME - 1) tick(1'b1, 1'b0, 16'h0, 1'b0);
      tick(1'b1, 1'b1, 16'hABCD, 1'b0);
      for (int c = 0; c < FRAME; c++) begin
         checks++;
         if ({bcd_out, dig_en, blank, frame_done} !== {e_bcd, e_en, e_blank, e_fd}
             || bcd_out == 4'h5) begin
            errors++;
            $display("FAIL boundary_load t=%0d got bcd=%h en=%b fd=%b exp bcd=%h en=%b fd=%b",
                     m_t, bcd_out, dig_en, frame_done, e_bcd, e_en, e_fd);
         end
         tick(1'b1, 1'b0, 16'h0, 1'b0);
      end
   endtask

   task automatic test_mid_reset();
      tick(1'b1, 1'b1, 16'h9876, 1'b0);
      while (m_t % FRAME != 0) tick(1'b1, 1'b0, 16'h0, 1'b0);
      while (m_t % FRAME != 2 * PS + 2) tick(1'b1, 1'b0, 16'h0, 1'b0);
      tick(1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (dig_en !== 4'h0 || blank !== 1'b1 || bcd_out !== 4'h0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got en=%b bl=%b bcd=%h fd=%b exp en=0000 bl=1 bcd=0 fd=0",
                  dig_en, blank, bcd_out, frame_done);
      end
      for (int c = 0; c < FRAME + 2; c++) begin
         tick(1'b1, 1'b0, 16'h0, 1'b0);
         checks++;
         if ({bcd_out, dig_en, blank, frame_done} !== {e_bcd, e_en, e_blank, e_fd}) begin
            errors++;
            $display("FAIL mid_reset_after t=%0d got bcd=%h en=%b fd=%b exp bcd=%h en=%b fd=%b",
                     m_t, bcd_out, dig_en, frame_done, e_bcd, e_en, e_fd);
         end
      end
   endtask

   task automatic test_random();
      logic        ld;
      logic        rst;
      logic        lz;
      logic [15:0] v;
      lz = 1'b0;
      for (int c = 0; c < 600; c++) begin
         ld  = ($urandom_range(0, 7) == 0);
         rst = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 31) == 0) lz = ~lz;
         // Bias toward zero nibbles so suppression is exercised.
         v = 16'($urandom) & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                              {4{$urandom_range(0, 1) == 1}}, 4'hF};
         tick(rst, ld, v, lz);
         checks++;
         if ({bcd_out, dig_en, blank, frame_done} !== {e_bcd, e_en, e_blank, e_fd}) begin
            errors++;
            $display("FAIL random t=%0d got bcd=%h en=%b bl=%b fd=%b exp bcd=%h en=%b bl=%b fd=%b",
                     m_t, bcd_out, dig_en, blank, frame_done, e_bcd, e_en, e_blank, e_fd);
         end
         checks++;
         if ((dig_en & (dig_en - 4'h1)) !== 4'h0) begin
            errors++;
            $display("FAIL onehot got en=%b exp at most one bit", dig_en);
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      load     = 1'b0;
      value_in = 16'h0;
      lz_en    = 1'b0;
      m_t      = 0;
      m_shadow = 16'h0;
      m_active = 16'h0;
      m_lz     = 1'b0;
      m_lastval = 16'h0;
      test_reset();
      test_load_frame();
      test_lz();
      test_no_tear();
      test_boundary_load();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
